pc_sequencer: RTL

Multi-cycle control FSM that sequences one RV32I instruction at a time through fetch, decode, execute, memory and writeback. It owns the PC opcode that drives `program_counter` and issues request/acknowledge handshakes to instruction and data memory. It also generates the register-file write strobe. It sits between the memories, the decoder/ALU/branch comparator and the PC register.

---
 rtl/riscv_pkg.sv | 69 ++++++
 rtl/seq_perf_counters.sv | 24 ++
 rtl/pc_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I sequencer types: opcodes, PC opcodes, FSM states and instruction classes.
// Also holds the opcode classifier used in DECODE.
package riscv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        PcStop,
        PcIncr,
        PcJAL,
        PcJALR,
        PcBranch
    } PcOps;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DECODE,
        EXEC,
        MEM,
        WB,
        HALT,
        TRAP
    } seq_state_e;

    typedef enum logic [3:0] {
        CLS_LUI,
        CLS_AUIPC,
        CLS_OP_IMM,
        CLS_OP,
        CLS_JAL,
        CLS_JALR,
        CLS_BRANCH,
        CLS_LOAD,
        CLS_STORE,
        CLS_SYSTEM,
        CLS_ILLEGAL
    } instr_class_e;

    function automatic instr_class_e classify(input logic [6:0] opcode);
        instr_class_e cls;
        case (opcode)
            OPC_LUI:    cls = CLS_LUI;
            OPC_AUIPC:  cls = CLS_AUIPC;
            OPC_OP_IMM: cls = CLS_OP_IMM;
            OPC_OP:     cls = CLS_OP;
            OPC_JAL:    cls = CLS_JAL;
            OPC_JALR:   cls = CLS_JALR;
            OPC_BRANCH: cls = CLS_BRANCH;
            OPC_LOAD:   cls = CLS_LOAD;
            OPC_STORE:  cls = CLS_STORE;
            OPC_SYSTEM: cls = CLS_SYSTEM;
            default:    cls = CLS_ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/seq_perf_counters.sv
// Cycle and retired-instruction counters for pc_sequencer.
// Only compiled when PC_SEQUENCER_PERF_EN is defined.
`ifdef PC_SEQUENCER_PERF_EN
module seq_perf_counters (
    input  logic        clk,
    input  logic        rstn,
    input  logic        count_en,
    input  logic        retire,
    output logic [63:0] cycle_cnt,
    output logic [63:0] instret_cnt
);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (count_en) cycle_cnt   <= cycle_cnt + 64'd1;
            if (retire)   instret_cnt <= instret_cnt + 64'd1;
        end
    end

endmodule
`endif

// File: rtl/pc_sequencer.sv
// Multi-cycle RV32I control FSM: fetch/decode/exec/mem/writeback with memory handshakes.
// PC_SEQUENCER_PERF_EN adds o_cycle_cnt / o_instret_cnt performance counters.
module pc_sequencer
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rstn,
    output logic            o_imem_req,
    input  logic            i_imem_ack,
    input  logic [XLEN-1:0] i_imem_rdata,
    output logic [XLEN-1:0] o_instr,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    input  logic            i_dmem_ack,
    input  logic            i_branch_taken,
    input  logic            i_resume,
    output PcOps            o_pc_op,
    output logic            o_rd_we,
    output logic            o_halted,
    output logic            o_trap
`ifdef PC_SEQUENCER_PERF_EN
    ,
    output logic [63:0]     o_cycle_cnt,
    output logic [63:0]     o_instret_cnt
`endif
);

    seq_state_e   state;
    seq_state_e   state_nx;
    instr_class_e cls_q;
    instr_class_e dec_cls;
    logic         taken_q;
    logic         is_ebreak;

    assign dec_cls   = classify(o_instr[6:0]);
    assign is_ebreak = (o_instr == XLEN'(INSTR_EBREAK));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            o_instr <= '0;
            cls_q   <= CLS_ILLEGAL;
            taken_q <= 1'b0;
        end else begin
            if (state == FETCH && i_imem_ack) o_instr <= i_imem_rdata;
            if (state == DECODE)              cls_q   <= dec_cls;
            if (state == EXEC)                taken_q <= i_branch_taken;
        end
    end

    always_comb begin
        state_nx   = state;
        o_imem_req = 1'b0;
        o_dmem_req = 1'b0;
        o_dmem_we  = 1'b0;
        o_pc_op    = PcStop;
        o_rd_we    = 1'b0;
        o_halted   = 1'b0;
        o_trap     = 1'b0;

        case (state)
            IDLE: state_nx = FETCH;
            FETCH: begin
                o_imem_req = 1'b1;
                if (i_imem_ack) state_nx = DECODE;
            end
            DECODE: begin
                case (dec_cls)
                    CLS_SYSTEM:  state_nx = is_ebreak ? HALT : TRAP;
                    CLS_ILLEGAL: state_nx = TRAP;
                    default:     state_nx = EXEC;
                endcase
            end
            EXEC: begin
                if (cls_q == CLS_LOAD || cls_q == CLS_STORE) state_nx = MEM;
                else                                         state_nx = WB;
            end
            MEM: begin
                o_dmem_req = 1'b1;
                o_dmem_we  = (cls_q == CLS_STORE);
                if (i_dmem_ack) state_nx = WB;
            end
            // The HALT-resume WB arrives with cls_q == CLS_SYSTEM, which
            // naturally yields PcIncr with no register write.
            WB: begin
                state_nx = FETCH;
                case (cls_q)
                    CLS_JAL:    o_pc_op = PcJAL;
                    CLS_JALR:   o_pc_op = PcJALR;
                    CLS_BRANCH: o_pc_op = taken_q ? PcBranch : PcIncr;
                    default:    o_pc_op = PcIncr;
                endcase
                o_rd_we = (cls_q inside {CLS_LUI, CLS_AUIPC, CLS_OP_IMM, CLS_OP,
                                         CLS_JAL, CLS_JALR, CLS_LOAD});
            end
            HALT: begin
                o_halted = 1'b1;
                if (i_resume) state_nx = WB;
            end
            TRAP: o_trap = 1'b1;
            default: state_nx = IDLE;
        endcase
    end

`ifdef PC_SEQUENCER_PERF_EN
    seq_perf_counters u_perf (
        .clk         (clk),
        .rstn        (rstn),
        .count_en    (!(state inside {IDLE, HALT, TRAP})),
        .retire      (state == WB && cls_q != CLS_SYSTEM),
        .cycle_cnt   (o_cycle_cnt),
        .instret_cnt (o_instret_cnt)
    );
`endif

endmodule
